opb_coeff_bank: RTL and testbench
=================================

OPB_COEFF_BANK -- requirements
Module: opb_coeff_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01000600, first byte of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010006FF, last byte of the slave window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, OPB address width.
REQ-004 SHALL have parameter C_OPB_DWIDTH, default 32, OPB data width.
REQ-005 SHALL have parameter NUM_REGS, default 8, range 1..32, number of coefficient words.
REQ-006 SHALL have parameter COMMIT_MODE, default 1: 1 = shadow plus atomic commit; 0 = write-through.
REQ-007 SHALL have parameter C_INIT, default 32'h0, reset value of every shadow and output word.
REQ-008 SHALL have port OPB_Clk, input, 1 bit, the only clock.
REQ-009 SHALL have port OPB_Rst, input, 1 bit, asynchronous active-high reset.
REQ-010 SHALL have port OPB_ABus, input, [0:31], address.
REQ-011 SHALL have port OPB_BE, input, [0:3], byte enables.
REQ-012 SHALL have port OPB_DBus, input, [0:31], write data.
REQ-013 SHALL have ports OPB_RNW, OPB_select and OPB_seqAddr, each input, 1 bit: read-not-write, slave select, sequential address (OPB_seqAddr is ignored).
REQ-014 SHALL have port Sl_DBus, output, [0:31], read data.
REQ-015 SHALL have port Sl_xferAck, output, 1 bit, transfer acknowledge.
REQ-016 SHALL have ports Sl_errAck, Sl_retry and Sl_toutSup, each output, 1 bit, tied to 0.
REQ-017 SHALL have port user_data_out, output, [NUM_REGS*32-1:0], active coefficients; word k occupies bits [32k+31:32k].
REQ-018 SHALL have port user_update, output, 1 bit, one-cycle pulse when user_data_out changes.

Function
REQ-019 A hit SHALL be OPB_select=1 with C_BASEADDR<=OPB_ABus<=C_HIGHADDR; word index = (OPB_ABus-C_BASEADDR)>>2.
REQ-020 Index 0 SHALL be CTRL; index 1..NUM_REGS SHALL be shadow[index-1]; all other in-window indices SHALL be acknowledged, read as 0, and ignore writes.
REQ-021 Handshake FSM SHALL have states IDLE, ACK and HOLD: IDLE->ACK on hit; ACK->HOLD unconditionally; HOLD->IDLE when OPB_select=0; HOLD->HOLD otherwise.
REQ-022 Sl_xferAck SHALL be 1 only in ACK, i.e. exactly one cycle, asserted one cycle after the hit is sampled.
REQ-023 Sl_DBus SHALL carry the read data only in ACK with OPB_RNW=1, and SHALL be all-zero otherwise (OR-bus).
REQ-024 Writes SHALL take effect on the IDLE->ACK edge, per byte: OPB_BE[n] enables OPB_DBus[8n:8n+7], which maps to value bits [31-8n:24-8n].
REQ-025 OPB bit 0 SHALL map to value bit 31.
REQ-026 CTRL read SHALL return {commit_count[15:0], 15'b0, pending}.
REQ-027 Any shadow write with at least one BE set SHALL set pending.
REQ-028 COMMIT_MODE=1: a CTRL write with OPB_BE[3]=1 and OPB_DBus[31]=1 SHALL, one cycle later, copy all shadows to user_data_out, pulse user_update, clear pending, and increment commit_count (0xFFFF wraps to 0x0000).
REQ-029 COMMIT_MODE=1: a commit with pending=0 SHALL still copy, pulse and increment.
REQ-030 COMMIT_MODE=1: a CTRL write with BE[3]=0 or bit 31=0 SHALL have no effect.
REQ-031 COMMIT_MODE=0: each shadow write SHALL update its user_data_out word one cycle later and pulse user_update; pending SHALL stay 0; CTRL writes SHALL be ignored.
REQ-032 A new hit while in HOLD SHALL NOT be acknowledged until the FSM has returned to IDLE.

Reset
REQ-033 OPB_Rst=1 SHALL immediately, asynchronously, force the FSM to IDLE, Sl_xferAck=0, Sl_DBus=0, user_update=0, pending=0, commit_count=0, and every shadow and user_data_out word to C_INIT.
REQ-034 OPB_Rst asserted during ACK SHALL abort the transfer with no acknowledge and no partial write.

Structure
REQ-035 Package opb_coeff_bank_pkg SHALL hold the FSM state enum, CTRL index, CTRL bit positions and the commit_count width.
REQ-036 The handshake FSM (REQ-021..023, REQ-032) SHALL be sub-module opb_slave_ack_fsm; register storage and commit logic SHALL stay in the top level.

Verification (NUM_REGS=4, COMMIT_MODE=1 unless stated)
REQ-037 Write 0xA5A5A5A5 to 0x01000604 -> Sl_xferAck high exactly one cycle, one cycle after select; shadow0=0xA5A5A5A5; user_data_out word0 still 0; CTRL read=0x00000001.
REQ-038 Write 0x00000001 to 0x01000600 -> next cycle word0=0xA5A5A5A5, user_update pulses once, CTRL read=0x00010000.
REQ-039 Write 0x11223344 with BE=0100 to 0x01000608 over shadow1=0 -> shadow1 reads 0x00220000.
REQ-040 Read 0x010006F0 -> acknowledged with Sl_DBus=0; a write to 0x010006F0 changes no state; outside Sl_xferAck cycles Sl_DBus=0.
REQ-041 Run 65536 commits -> commit_count wraps to 0x0000; COMMIT_MODE=0 write 0xDEADBEEF to 0x01000610 -> word3=0xDEADBEEF one cycle later with a user_update pulse.
REQ-042 Assert OPB_Rst in the ACK cycle of a shadow write -> Sl_xferAck drops immediately and all words return to C_INIT.

Source files
------------

// File: rtl/opb_coeff_bank_pkg.sv
// Shared types and constants for the OPB coefficient bank: handshake states,
// CTRL word layout and the byte-lane merge helper.
package opb_coeff_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } ack_state_e;

  localparam int CTRL_IDX         = 0;
  localparam int CTRL_PENDING_BIT = 0;
  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int COUNT_W          = 16;
  localparam int COUNT_LSB        = 16;

  // be_v[b] enables value byte b, i.e. bits [8b+7:8b]
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be_v);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be_v[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave handshake: one acknowledge cycle per hit, then wait for the
// master to drop select before accepting another transfer.
//
//   state | meaning
//   IDLE  | waiting for a hit; a hit is accepted (and written) on leaving
//   ACK   | Sl_xferAck asserted for this single cycle, read data driven
//   HOLD  | transfer done, waiting for OPB_select to fall
module opb_slave_ack_fsm
  import opb_coeff_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic select,
  input  logic hit,
  output logic ack,
  output logic accept
);

  ack_state_e state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = ACK;
          accept    = 1'b1;
        end
      end
      ACK:  state_nxt = HOLD;
      HOLD: if (!select) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ack = (state == ACK);

endmodule

// File: rtl/opb_coeff_bank.sv
// OPB slave holding NUM_REGS coefficient words behind a shadow bank, with an
// atomic commit (COMMIT_MODE=1) or per-word write-through (COMMIT_MODE=0).
module opb_coeff_bank
  import opb_coeff_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01000600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010006FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          NUM_REGS     = 8,
  parameter int          COMMIT_MODE  = 1,
  parameter logic [31:0] C_INIT       = 32'h0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:31]              OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:31]              OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:31]              Sl_DBus,
  output logic                     Sl_xferAck,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic [NUM_REGS*32-1:0]   user_data_out,
  output logic                     user_update
);

  logic [31:0] addr, wdata, offset, idx, idx_q, rdata;
  logic [3:0]  be;
  logic        hit, accept, ack, wr;
  logic        ctrl_hit, shadow_hit, commit_set, pend_set;
  logic        commit_req, pending;
  logic [COUNT_W-1:0]          commit_count;
  logic [NUM_REGS-1:0][31:0]   shadow, active;
  logic        unused_ok;

  // OPB bit 0 is the MSB, so plain packed assignment gives value ordering
  assign addr   = OPB_ABus;
  assign wdata  = OPB_DBus;
  assign be     = OPB_BE;
  assign offset = addr - C_BASEADDR;
  assign idx    = offset >> 2;

  assign hit        = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign wr         = accept && !OPB_RNW;
  assign ctrl_hit   = (idx == 32'(CTRL_IDX));
  assign shadow_hit = (idx >= 32'd1) && (idx <= 32'(NUM_REGS));

  assign commit_set = (COMMIT_MODE != 0)
                    ? (wr && ctrl_hit && be[0] && wdata[CTRL_COMMIT_BIT])
                    : (wr && shadow_hit && (|be));
  assign pend_set   = (COMMIT_MODE != 0) && wr && shadow_hit && (|be);

  opb_slave_ack_fsm u_ack_fsm (
    .clk    (OPB_Clk),
    .rst    (OPB_Rst),
    .select (OPB_select),
    .hit    (hit),
    .ack    (ack),
    .accept (accept)
  );

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      shadow       <= {NUM_REGS{C_INIT}};
      active       <= {NUM_REGS{C_INIT}};
      idx_q        <= '0;
      commit_req   <= 1'b0;
      user_update  <= 1'b0;
      pending      <= 1'b0;
      commit_count <= '0;
    end else begin
      commit_req  <= commit_set;
      user_update <= commit_req;
      if (accept) idx_q <= idx;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr && (idx == 32'(k + 1))) shadow[k] <= merge_bytes(shadow[k], wdata, be);
      end
      // In write-through mode shadows always equal the outputs, so copying
      // the whole bank is the same as copying the one written word.
      if (commit_req) begin
        active <= shadow;
        if (COMMIT_MODE != 0) begin
          commit_count <= commit_count + 1'b1;
          pending      <= 1'b0;
        end
      end else if (pend_set) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (idx_q == 32'(CTRL_IDX)) begin
      rdata[COUNT_LSB +: COUNT_W]  = commit_count;
      rdata[CTRL_PENDING_BIT]      = pending;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (idx_q == 32'(k + 1)) rdata = shadow[k];
      end
    end
  end

  assign Sl_DBus       = (ack && OPB_RNW) ? rdata : 32'h0;
  assign Sl_xferAck    = ack;
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_data_out = active;

  assign unused_ok = &{1'b0, OPB_seqAddr, (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32)};

endmodule

// File: tb/tb_opb_coeff_bank.sv
// Directed bench for opb_coeff_bank: a commit-mode and a write-through
// instance driven from one vector table plus a few multi-cycle sequences.
module tb_opb_coeff_bank;

  localparam logic [31:0]  INIT0 = 32'h5A5A0000;
  localparam logic [127:0] I0 = {4{INIT0}};
  localparam logic [127:0] U0 = 128'h0;
  localparam logic [127:0] UA = {96'h0, 32'hA5A5A5A5};
  localparam logic [127:0] UB = {32'h12345678, 32'h0, 32'h00220000, 32'hA5A5A5A5};
  localparam logic [127:0] UM0 = {32'hDEADBEEF, INIT0, INIT0, INIT0};
  localparam logic [127:0] UM1 = {32'hDEADBEEF, INIT0, INIT0, 32'h775A0000};

  logic clk = 1'b0;
  logic rst;
  logic [0:31] abus, dbus;
  logic [0:3]  be;
  logic rnw, seq, sel1, sel0;
  logic [0:31] dbus1, dbus0;
  logic ack1, err1, retry1, tout1, upd1;
  logic ack0, err0, retry0, tout0, upd0;
  logic [127:0] user1, user0;

  int checks = 0;
  int errors = 0;
  int upd1_cnt = 0;
  int upd0_cnt = 0;
  int bus_viol = 0;

  always #5 clk = ~clk;

  opb_coeff_bank #(.NUM_REGS(4), .COMMIT_MODE(1)) dut1 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(seq),
    .Sl_DBus(dbus1), .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(retry1),
    .Sl_toutSup(tout1), .user_data_out(user1), .user_update(upd1));

  opb_coeff_bank #(.NUM_REGS(4), .COMMIT_MODE(0), .C_INIT(INIT0)) dut0 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel0), .OPB_seqAddr(seq),
    .Sl_DBus(dbus0), .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(retry0),
    .Sl_toutSup(tout0), .user_data_out(user0), .user_update(upd0));

  always @(negedge clk) begin
    if (upd1) upd1_cnt++;
    if (upd0) upd0_cnt++;
    if ((!(ack1 && rnw) && dbus1 != 32'h0) || (!(ack0 && rnw) && dbus0 != 32'h0) ||
        err1 || retry1 || tout1 || err0 || retry0 || tout0)
      bus_viol++;
  end

  typedef struct {
    bit           inst;
    bit           rnw;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  data;
    bit           exp_ack;
    logic [31:0]  exp_rd;
    logic [127:0] exp_user;
    int           exp_upd;
    bit           chk_uack;
    logic [127:0] exp_uack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit inst, bit r, logic [31:0] a, logic [3:0] b, logic [31:0] d,
                              bit ea, logic [31:0] er, logic [127:0] eu, int eup);
    vec_t v;
    v.inst = inst; v.rnw = r; v.addr = a; v.be = b; v.data = d;
    v.exp_ack = ea; v.exp_rd = er; v.exp_user = eu; v.exp_upd = eup;
    v.chk_uack = 1'b0; v.exp_uack = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input bit inst, input bit r, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output int n,
                      output int first, output logic [127:0] uack);
    @(negedge clk);
    abus = a; be = b; dbus = d; rnw = r;
    if (inst) sel1 = 1'b1; else sel0 = 1'b1;
    n = 0; first = 0; rd = '0; uack = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (inst ? ack1 : ack0) begin
        n++;
        if (first == 0) first = c;
        rd   = inst ? dbus1 : dbus0;
        uack = inst ? user1 : user0;
      end else if (n > 0) begin
        break;
      end
    end
    sel1 = 1'b0; sel0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0]  rd;
    logic [127:0] uack;
    int n, first, u_before;
    u_before = v.inst ? upd1_cnt : upd0_cnt;
    xfer(v.inst, v.rnw, v.addr, v.be, v.data, rd, n, first, uack);
    chk({tag, "_ackcount"}, n, v.exp_ack ? 1 : 0);
    if (v.exp_ack) chk({tag, "_acklat"}, first, 1);
    if (v.rnw && v.exp_ack) chk({tag, "_rdata"}, rd, v.exp_rd);
    if (v.chk_uack) chk({tag, "_user_at_ack"}, uack, v.exp_uack);
    chk({tag, "_user"}, v.inst ? user1 : user0, v.exp_user);
    chk({tag, "_updates"}, (v.inst ? upd1_cnt : upd0_cnt) - u_before, v.exp_upd);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; abus = '0; dbus = '0; be = '0; rnw = 1'b0; seq = 1'b0;
    sel1 = 1'b0; sel0 = 1'b0;

    // commit-mode instance
    tbl.push_back(mk(1, 0, 32'h01000604, 4'hF, 32'hA5A5A5A5, 1, 0, U0, 0));
    tbl.push_back(mk(1, 1, 32'h01000604, 4'hF, 0, 1, 32'hA5A5A5A5, U0, 0));
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00000001, U0, 0));
    tbl.push_back(mk(1, 0, 32'h01000600, 4'hF, 32'h00000001, 1, 0, UA, 1));
    tbl[$].chk_uack = 1'b1; tbl[$].exp_uack = U0;
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00010000, UA, 0));
    tbl.push_back(mk(1, 0, 32'h01000608, 4'b0100, 32'h11223344, 1, 0, UA, 0));
    tbl.push_back(mk(1, 1, 32'h01000608, 4'hF, 0, 1, 32'h00220000, UA, 0));
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00010001, UA, 0));
    tbl.push_back(mk(1, 0, 32'h01000600, 4'b1110, 32'h00000001, 1, 0, UA, 0));
    tbl.push_back(mk(1, 0, 32'h01000600, 4'hF, 32'h00000000, 1, 0, UA, 0));
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00010001, UA, 0));
    tbl.push_back(mk(1, 1, 32'h010006F0, 4'hF, 0, 1, 32'h0, UA, 0));
    tbl.push_back(mk(1, 0, 32'h010006F0, 4'hF, 32'hFFFFFFFF, 1, 0, UA, 0));
    tbl.push_back(mk(1, 0, 32'h01000614, 4'hF, 32'hFFFFFFFF, 1, 0, UA, 0));
    tbl.push_back(mk(1, 1, 32'h01000614, 4'hF, 0, 1, 32'h0, UA, 0));
    tbl.push_back(mk(1, 1, 32'h01000610, 4'hF, 0, 1, 32'h0, UA, 0));
    tbl.push_back(mk(1, 1, 32'h01000604, 4'hF, 0, 1, 32'hA5A5A5A5, UA, 0));
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00010001, UA, 0));
    tbl.push_back(mk(1, 0, 32'h01000610, 4'hF, 32'h12345678, 1, 0, UA, 0));
    tbl.push_back(mk(1, 0, 32'h01000600, 4'b0001, 32'h00000001, 1, 0, UB, 1));
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00020000, UB, 0));
    tbl.push_back(mk(1, 0, 32'h01000600, 4'b0001, 32'h00000001, 1, 0, UB, 1));
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00030000, UB, 0));
    tbl.push_back(mk(1, 0, 32'h01000604, 4'b0000, 32'hFFFFFFFF, 1, 0, UB, 0));
    tbl.push_back(mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00030000, UB, 0));
    tbl.push_back(mk(1, 1, 32'h01000604, 4'hF, 0, 1, 32'hA5A5A5A5, UB, 0));
    tbl.push_back(mk(1, 1, 32'h01000700, 4'hF, 0, 0, 0, UB, 0));
    tbl.push_back(mk(1, 1, 32'h010005FC, 4'hF, 0, 0, 0, UB, 0));
    // write-through instance
    tbl.push_back(mk(0, 1, 32'h01000600, 4'hF, 0, 1, 32'h0, I0, 0));
    tbl.push_back(mk(0, 0, 32'h01000610, 4'hF, 32'hDEADBEEF, 1, 0, UM0, 1));
    tbl[$].chk_uack = 1'b1; tbl[$].exp_uack = I0;
    tbl.push_back(mk(0, 1, 32'h01000610, 4'hF, 0, 1, 32'hDEADBEEF, UM0, 0));
    tbl.push_back(mk(0, 0, 32'h01000600, 4'hF, 32'h00000001, 1, 0, UM0, 0));
    tbl.push_back(mk(0, 1, 32'h01000600, 4'hF, 0, 1, 32'h0, UM0, 0));
    tbl.push_back(mk(0, 0, 32'h01000604, 4'b1000, 32'h77000000, 1, 0, UM1, 1));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_user1", user1, U0);
    chk("reset_user0", user0, I0);
    chk("reset_ack", {ack1, ack0}, 2'b00);
    chk("reset_update", {upd1, upd0}, 2'b00);

    foreach (tbl[i]) run_vec($sformatf("v%0d", i), tbl[i]);

    // a select held high through HOLD must not be acknowledged twice
    @(negedge clk);
    abus = 32'h01000604; rnw = 1'b1; be = 4'hF; sel1 = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (ack1) n++; end
    chk("hold_single_ack", n, 1);
    sel1 = 1'b0;
    @(negedge clk);
    sel1 = 1'b1;
    n = 0;
    repeat (3) begin @(negedge clk); if (ack1) n++; end
    chk("hold_reaccept", n, 1);
    sel1 = 1'b0;
    @(negedge clk);

    // commit counter wrap, starting just below the top
    force dut1.commit_count = 16'hFFFE;
    @(negedge clk);
    release dut1.commit_count;
    run_vec("wrap_a", mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'hFFFE0000, UB, 0));
    run_vec("wrap_b", mk(1, 0, 32'h01000600, 4'b0001, 32'h1, 1, 0, UB, 1));
    run_vec("wrap_c", mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'hFFFF0000, UB, 0));
    run_vec("wrap_d", mk(1, 0, 32'h01000600, 4'b0001, 32'h1, 1, 0, UB, 1));
    run_vec("wrap_e", mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h00000000, UB, 0));

    // reset landing in the ACK cycle of a shadow write
    @(negedge clk);
    abus = 32'h0100060C; be = 4'hF; dbus = 32'hCAFEF00D; rnw = 1'b0; sel1 = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_pre_ack", ack1, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_ack_drop", ack1, 1'b0);
    chk("rst_dbus", dbus1, 32'h0);
    chk("rst_user1", user1, U0);
    chk("rst_user0", user0, I0);
    chk("rst_update", {upd1, upd0}, 2'b00);
    @(negedge clk);
    sel1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec("post_rst_sh2", mk(1, 1, 32'h0100060C, 4'hF, 0, 1, 32'h0, U0, 0));
    run_vec("post_rst_sh0", mk(1, 1, 32'h01000604, 4'hF, 0, 1, 32'h0, U0, 0));
    run_vec("post_rst_ctrl", mk(1, 1, 32'h01000600, 4'hF, 0, 1, 32'h0, U0, 0));

    chk("bus_idle_zero", bus_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
